// File: rtl/frac_tickgen_pkg.sv
// Shared constants for the fractional PPU/CPU tick generator: region encoding,
// CPU divider ratios and the default accumulator scale.
package frac_tickgen_pkg;

  localparam int SCALE_LOG2_DEFAULT = 16;
  localparam int CACC_W             = 5;

  typedef enum logic {
    REGION_NTSC = 1'b0,
    REGION_PAL  = 1'b1
  } region_e;

  // PPU ticks per CPU tick expressed as NUM/DEN: NTSC 3/1, PAL 16/5.
  localparam logic [CACC_W-1:0] NUM_NTSC = 5'd3;
  localparam logic [CACC_W-1:0] DEN_NTSC = 5'd1;
  localparam logic [CACC_W-1:0] NUM_PAL  = 5'd16;
  localparam logic [CACC_W-1:0] DEN_PAL  = 5'd5;

  function automatic logic [CACC_W-1:0] region_num(input logic pal);
    return (region_e'(pal) == REGION_PAL) ? NUM_PAL : NUM_NTSC;
  endfunction

  function automatic logic [CACC_W-1:0] region_den(input logic pal);
    return (region_e'(pal) == REGION_PAL) ? DEN_PAL : DEN_NTSC;
  endfunction

endpackage

// File: rtl/frac_div.sv
// CPU divider: fractional NUM/DEN accumulator advanced once per PPU tick;
// isc marks the PPU tick that also carries a CPU tick.
module frac_div
  import frac_tickgen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pal_q,
  input  logic reload,
  output logic isc
);

  logic [CACC_W-1:0] cacc;
  logic [CACC_W-1:0] num;
  logic [CACC_W-1:0] den;
  logic [CACC_W:0]   sum;
  logic [CACC_W:0]   wrapped;

  always_comb begin
    num     = region_num(pal_q);
    den     = region_den(pal_q);
    sum     = {1'b0, cacc} + {1'b0, den};
    wrapped = sum - {1'b0, num};
    isc     = (cacc < den);
  end

  // A region change restarts the divider at the new DEN so the following
  // CPU tick lands a full new-region period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cacc <= '0;
    end else if (reload) begin
      cacc <= region_den(!pal_q);
    end else if (tick) begin
      if (sum >= {1'b0, num}) cacc <= wrapped[CACC_W-1:0];
      else                    cacc <= sum[CACC_W-1:0];
    end
  end

endmodule

// File: rtl/frac_tickgen.sv
// Fractional PPU/CPU tick generator with banked credit and overrun flag.
// Optional tick statistics counters are enabled by defining TICKGEN_STATS_EN.
module frac_tickgen
  import frac_tickgen_pkg::*;
#(
  parameter int SCALE_LOG2 = SCALE_LOG2_DEFAULT,
  parameter int INC_NTSC   = 7037,
  parameter int INC_PAL    = 6973,
  parameter int BACKLOG    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        memdone,
  input  logic        ppudone,
  input  logic        pal,
  output logic        cputick,
  output logic        pputick,
  output logic        cputick_,
  output logic        pputick_,
  output logic        overrun,
  output logic [31:0] ppucnt,
  output logic [31:0] cpucnt
);

  localparam int CTR_W = SCALE_LOG2 + $clog2(BACKLOG) + 1;
  localparam int SUM_W = CTR_W + 1;
  localparam logic [SUM_W-1:0] SCALE = SUM_W'(1) << SCALE_LOG2;
  localparam logic [SUM_W-1:0] CAP   = SUM_W'(BACKLOG) << SCALE_LOG2;
  localparam logic [SUM_W-1:0] INC_N = SUM_W'(INC_NTSC);
  localparam logic [SUM_W-1:0] INC_P = SUM_W'(INC_PAL);

  logic [CTR_W-1:0] ctr;
  logic             pal_q;
  logic             isc;
  logic             advance;
  logic             reload;
  logic [SUM_W-1:0] ctr_ext;
  logic [SUM_W-1:0] ctr_next;

  // ppudone and memdone act as ready: a tick is issued only when credit is
  // banked (valid) and the consumer is ready; a CPU-carrying tick also needs
  // memdone, and no tick may follow a tick on the very next cycle.
  always_comb begin
    ctr_ext  = {1'b0, ctr};
    pputick_ = (ctr_ext >= SCALE) && !pputick && ppudone && (!isc || memdone);
    cputick_ = pputick_ && isc;
    ctr_next = ctr_ext + (pal_q ? INC_P : INC_N) - (pputick_ ? SCALE : '0);
  end

  assign advance = pputick_ && !stall;
  assign reload  = cputick_ && !stall && (pal != pal_q);

  frac_div u_div (
    .clk    (clk),
    .rst    (rst),
    .tick   (advance),
    .pal_q  (pal_q),
    .reload (reload),
    .isc    (isc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr     <= '0;
      pal_q   <= pal;
      cputick <= 1'b0;
      pputick <= 1'b0;
      overrun <= 1'b0;
    end else if (stall) begin
      cputick <= 1'b0;
      pputick <= 1'b0;
    end else begin
      cputick <= cputick_;
      pputick <= pputick_;
      // Subtraction is already folded into ctr_next, so the clamp sees the net value.
      if (ctr_next > CAP) begin
        ctr     <= CTR_W'(CAP);
        overrun <= 1'b1;
      end else begin
        ctr <= CTR_W'(ctr_next);
      end
      if (cputick_) pal_q <= pal;
    end
  end

`ifdef TICKGEN_STATS_EN
  logic [31:0] ppu_q;
  logic [31:0] cpu_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_q <= '0;
      cpu_q <= '0;
    end else if (!stall) begin
      if (pputick_) ppu_q <= ppu_q + 32'd1;
      if (cputick_) cpu_q <= cpu_q + 32'd1;
    end
  end

  assign ppucnt = ppu_q;
  assign cpucnt = cpu_q;
`else
  assign ppucnt = '0;
  assign cpucnt = '0;
`endif

endmodule

// File: tb/tb_frac_tickgen.sv
// Self-checking bench for frac_tickgen: directed scenarios feed an expected
// cputick-per-pputick queue that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_frac_tickgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        memdone;
  logic        ppudone;
  logic        pal;
  logic        cputick;
  logic        pputick;
  logic        cputick_;
  logic        pputick_;
  logic        overrun;
  logic [31:0] ppucnt;
  logic [31:0] cpucnt;

  frac_tickgen dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .memdone  (memdone),
    .ppudone  (ppudone),
    .pal      (pal),
    .cputick  (cputick),
    .pputick  (pputick),
    .cputick_ (cputick_),
    .pputick_ (pputick_),
    .overrun  (overrun),
    .ppucnt   (ppucnt),
    .cpucnt   (cpucnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_v;
  bit         sb_en    = 1'b0;
  int         cyc      = 0;
  int         pp_seen  = 0;
  int         cpu_seen = 0;
  int         tick_cyc[$];
  logic       prev_pp  = 1'b0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input longint actual,
                             input longint lo, input longint hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  function automatic int tc(input int i);
    return (i < tick_cyc.size()) ? tick_cyc[i] : -1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  // cyc counts negedges since reset release; tick_cyc records when pputick is seen.
  always @(negedge clk) begin
    if (rst) begin
      cyc      = 0;
      pp_seen  = 0;
      cpu_seen = 0;
      prev_pp  = 1'b0;
      tick_cyc.delete();
    end else begin
      cyc++;
      if (cputick) check("cpu_implies_ppu", pputick, 1);
      if (pputick) begin
        check("ppu_spacing", prev_pp, 0);
        pp_seen++;
        tick_cyc.push_back(cyc);
        if (cputick) cpu_seen++;
        if (sb_en) begin
          check("sb_depth", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("sb_cputick", cputick, exp_v);
          end
        end
      end
      prev_pp = pputick;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic pal_v);
    sb_en = 1'b0;
    exp_q.delete();
    step(1);
    rst     = 1'b1;
    pal     = pal_v;
    stall   = 1'b0;
    memdone = 1'b1;
    ppudone = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic push_pattern(input int n, input logic [31:0] mask);
    for (int i = 0; i < n; i++) exp_q.push_back(mask[i]);
  endtask

  task automatic wait_pp(input int n, input int budget, input string name);
    int k = 0;
    while (pp_seen < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, pp_seen >= n, 1);
  endtask

  task automatic check_stats(input string name, input int exp_pp, input int exp_cpu);
`ifdef TICKGEN_STATS_EN
    check({name, "_ppucnt"}, ppucnt, exp_pp);
    check({name, "_cpucnt"}, cpucnt, exp_cpu);
`else
    check({name, "_ppucnt_tied"}, ppucnt, exp_pp * 0);
    check({name, "_cpucnt_tied"}, cpucnt, exp_cpu * 0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    stall   = 1'b0;
    memdone = 1'b1;
    ppudone = 1'b1;
    pal     = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pputick", pputick, 0);
    check("rst_cputick", cputick, 0);
    check("rst_pputick_", pputick_, 0);
    check("rst_cputick_", cputick_, 0);
    check("rst_overrun", overrun, 0);
    check_stats("rst", 0, 0);

    // NTSC rate: first ticks at negedges 12 and 21, 2147+-1 ticks in 20000 clk
    for (int i = 0; i < 2200; i++) exp_q.push_back((i % 3) == 0);
    sb_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(20000);
    sb_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    check("ntsc_first_tick", tc(0), 12);
    check("ntsc_second_tick", tc(1), 21);
    check_range("ntsc_rate", pp_seen, 2146, 2148);
    check("ntsc_cpu_ratio", cpu_seen, (pp_seen + 2) / 3);
    check("ntsc_no_overrun", overrun, 0);
    check_stats("ntsc", pp_seen, cpu_seen);

    // PAL from reset: CPU ticks on PPU ticks 0,4,7,10,13,16
    do_reset(1'b1);
    push_pattern(17, 32'h0001_2491);
    sb_en = 1'b1;
    wait_pp(17, 400, "pal_reached");
    sb_en = 1'b0;
    check("pal_sb_drained", exp_q.size(), 0);
    check("pal_cpu_count", cpu_seen, 6);

    // Saturation: ppudone low 200 clk, then drain at alternate cycles
    do_reset(1'b0);
    ppudone = 1'b0;
    step(50);
    check("ovr_not_yet", overrun, 0);
    step(150);
    check("ovr_set", overrun, 1);
    check("ovr_no_ticks", pp_seen, 0);
    check("ovr_lookahead_blocked", pputick_, 0);
    push_pattern(12, 32'h0000_0249);
    sb_en   = 1'b1;
    ppudone = 1'b1;
    wait_pp(12, 200, "ovr_drain_reached");
    sb_en = 1'b0;
    for (int i = 1; i <= 8; i++) check($sformatf("ovr_drain_gap%0d", i), tc(i) - tc(i - 1), 2);
    check("ovr_drain_gap9", tc(9) - tc(8), 3);
    check("ovr_nominal_gap", tc(10) - tc(9), 9);
    check("ovr_sticky", overrun, 1);
    check("ovr_sb_drained", exp_q.size(), 0);

    // memdone gates only the CPU-carrying ticks
    do_reset(1'b0);
    memdone = 1'b0;
    step(100);
    check("mem_blocked", pp_seen, 0);
    check("mem_cpu_lookahead", cputick_, 0);
    push_pattern(4, 32'h0000_0009);
    sb_en   = 1'b1;
    memdone = 1'b1;
    step(1);
    memdone = 1'b0;
    step(40);
    check("mem_non_cpu_ticks", pp_seen, 3);
    check("mem_cpu_once", cpu_seen, 1);
    check("mem_gate_again", pputick_, 0);
    memdone = 1'b1;
    wait_pp(4, 10, "mem_resume");
    sb_en = 1'b0;
    check("mem_sb_drained", exp_q.size(), 0);
    check("mem_cpu_twice", cpu_seen, 2);

    // Region switch between CPU ticks: takes effect at next CPU tick (3), then 4 later (7)
    do_reset(1'b0);
    push_pattern(11, 32'h0000_0489);
    sb_en = 1'b1;
    wait_pp(2, 100, "sw_pre");
    pal = 1'b1;
    wait_pp(11, 300, "sw_reached");
    sb_en = 1'b0;
    check("sw_sb_drained", exp_q.size(), 0);
    check("sw_cpu_count", cpu_seen, 4);

    // Stall 50 clk right after the first tick: next tick delayed by exactly 50
    do_reset(1'b0);
    wait_pp(1, 50, "stall_first");
    stall = 1'b1;
    step(50);
    check("stall_no_ticks", pp_seen, 1);
    check_stats("stall_hold", 1, 1);
    stall = 1'b0;
    wait_pp(2, 100, "stall_resume");
    check("stall_next_tick", tc(1), 71);

    // Reset during stall with banked credit discards the backlog
    do_reset(1'b0);
    ppudone = 1'b0;
    step(100);
    check("bank_overrun", overrun, 1);
    stall   = 1'b1;
    ppudone = 1'b1;
    step(3);
    check("bank_stall_lookahead", pputick_, 1);
    check("bank_stall_quiet", pp_seen, 0);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    check("srst_overrun", overrun, 0);
    check("srst_pputick", pputick, 0);
    check("srst_cputick", cputick, 0);
    check("srst_lookahead", pputick_, 0);
    check_stats("srst", 0, 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    wait_pp(1, 50, "srst_refill");
    check("srst_first_tick", tc(0), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
